// File: rtl/fifo_operand_loader.sv
// Drains the byte FIFO into two OP_WIDTH-bit operands (A then B, LSB byte first)
// and offers the pair to the multiplier core under a valid/ready handshake.
module fifo_operand_loader #(
  parameter int OP_WIDTH = 288
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fifo_empty,
  input  logic [7:0]          fifo_rd_data,
  output logic                fifo_rd_en,
  output logic [OP_WIDTH-1:0] op_a,
  output logic [OP_WIDTH-1:0] op_b,
  output logic                op_valid,
  input  logic                op_ready,
  output logic                busy
);

  localparam int NBYTES = OP_WIDTH / 8;
  localparam int CW     = $clog2(2 * NBYTES + 1);
  localparam logic [CW-1:0] TOTAL = CW'(2 * NBYTES);
  localparam logic [CW-1:0] LAST  = CW'(2 * NBYTES - 1);

  typedef enum logic {LOAD, PRESENT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] cap_cnt;
  logic          rd_pend;
  logic          rd_acc;
  logic          cap_last;
  logic          accept;

  assign rd_acc   = fifo_rd_en;
  assign cap_last = rd_pend && (cap_cnt == LAST);
  assign accept   = (state == PRESENT) && op_valid && op_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // rst_n gates the strobe so nothing is popped while the block is held in reset
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    busy       = 1'b0;
    case (state)
      LOAD: begin
        fifo_rd_en = rst_n && !fifo_empty && (issue_cnt < TOTAL);
        busy       = (cap_cnt != '0);
        if (cap_last) state_nxt = PRESENT;
      end
      PRESENT: begin
        if (accept) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      cap_cnt   <= '0;
      rd_pend   <= 1'b0;
      op_valid  <= 1'b0;
    end else begin
      rd_pend  <= rd_acc;
      op_valid <= (state_nxt == PRESENT);
      if (accept) begin
        issue_cnt <= '0;
        cap_cnt   <= '0;
      end else begin
        if (rd_acc)  issue_cnt <= issue_cnt + 1'b1;
        if (rd_pend) cap_cnt   <= cap_cnt + 1'b1;
      end
    end
  end

  // Byte lanes are not cleared between pairs; every lane is rewritten before op_valid rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
    end else if (rd_pend) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (cap_cnt == CW'(i))          op_a[8*i +: 8] <= fifo_rd_data;
        if (cap_cnt == CW'(NBYTES + i)) op_b[8*i +: 8] <= fifo_rd_data;
      end
    end
  end

endmodule

// File: doc/fifo_operand_loader.md
Name: fifo_operand_loader

Overview:
- Read-side consumer of the 8-bit byte FIFO in front of the vedic multiplier.
- Pops bytes from the FIFO read port and assembles two OP_WIDTH-bit operands, A first then B, least-significant byte first.
- Presents the operand pair to the multiplier core with a valid/ready handshake and holds it until accepted.

Parameters:
- OP_WIDTH, 288, operand width in bits; must be a multiple of 8.
- NBYTES, OP_WIDTH/8 (36), bytes per operand; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_data  in  8  FIFO read data; valid the cycle after an accepted read.
- fifo_rd_en  out  1  FIFO read strobe.
- op_a  out  OP_WIDTH  assembled operand A.
- op_b  out  OP_WIDTH  assembled operand B.
- op_valid  out  1  operand pair complete and stable.
- op_ready  in  1  multiplier accepts the pair.
- busy  out  1  high while in LOAD with at least one byte captured.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=LOAD; issue_cnt, cap_cnt and rd_pend clear to 0.
  - op_a, op_b, op_valid and busy clear to 0.
  - fifo_rd_en=0 while in reset.
- FIFO read timing:
  - A read is accepted in a cycle where fifo_rd_en=1 and fifo_empty=0.
  - fifo_rd_data holds that byte on the following cycle.
- fifo_rd_en is combinational: (state==LOAD) and (fifo_empty==0) and (issue_cnt < 2*NBYTES).
  - Never asserted while empty.
  - Never asserted in PRESENT.
  - Never more than 2*NBYTES reads per pair.
- issue_cnt, range 0..2*NBYTES: increments on every accepted read.
- rd_pend: registered copy of the accepted-read condition, marking a byte to capture this cycle.
- Capture, on rd_pend=1:
  - cap_cnt < NBYTES: fifo_rd_data is written to op_a[8*cap_cnt +: 8].
  - Otherwise: fifo_rd_data is written to op_b[8*(cap_cnt-NBYTES) +: 8].
  - cap_cnt then increments.
- Back-to-back reads give one byte per clock; a full pair costs 2*NBYTES+1 cycles when the FIFO never runs empty.
- Gaps (FIFO empty mid-operand) stall assembly only. Captured bytes are retained and ordering is preserved.
- States:
  - LOAD -> PRESENT on the cycle the capture makes cap_cnt reach 2*NBYTES. op_valid=1 from the next cycle.
  - PRESENT: op_a, op_b and op_valid stay stable; no reads are issued.
  - PRESENT -> LOAD on the cycle where op_valid and op_ready are both 1. Next cycle: op_valid=0, issue_cnt=0, cap_cnt=0, and reads may resume the same cycle LOAD is entered.
  - op_ready high before op_valid has no effect.
  - op_ready held permanently high gives one pair per 2*NBYTES+2 cycles.
- Register clearing on restart: op_a and op_b are not cleared on return to LOAD. Every byte lane is overwritten before op_valid rises again.
- busy = (state==LOAD) and (cap_cnt != 0).
- Reset mid-operation:
  - The partial pair and any in-flight read are discarded.
  - Bytes already popped are lost. The upstream writer must reframe (flush the FIFO) after reset.
- Widths:
  - issue_cnt and cap_cnt are each $clog2(2*NBYTES+1) bits.
  - The byte index is computed at counter width; no wrap occurs within a pair.

Test Plan:
- Reset: OP_WIDTH=288, assert rst_n=0 mid-load after 10 bytes -> op_valid=0, op_a=0, busy=0, fifo_rd_en=0. After release, the next 72 bytes form a clean pair.
- Streaming: OP_WIDTH=16, FIFO preloaded with 0x11,0x22,0x33,0x44, op_ready=1 -> fifo_rd_en high exactly 4 cycles; op_a=0x2211, op_b=0x4433; op_valid high one cycle, 5 cycles after the first read.
- Stall: OP_WIDTH=16, bytes 0xA1,0xB2 then FIFO empty 6 cycles then 0xC3,0xD4 -> fifo_rd_en=0 during the gap; busy=1 during the gap; op_a=0xB2A1, op_b=0xD4C3.
- Backpressure: OP_WIDTH=16, op_ready=0 for 20 cycles after op_valid with 8 bytes in the FIFO -> no fifo_rd_en while in PRESENT; outputs stable. op_ready pulse -> next pair loads from byte 5.
- Full width: OP_WIDTH=288, bytes 0x00..0x47 -> op_a[7:0]=0x00, op_a[287:280]=0x23, op_b[7:0]=0x24, op_b[287:280]=0x47.
- Over-read guard: OP_WIDTH=16, FIFO holds 6 bytes, op_ready=0 -> exactly 4 reads issued; 2 bytes remain in the FIFO.
